writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final stage of the 4-stage pipeline; sits directly upstream of the 8x8 register file and drives its write port (write_reg, write_data, regwrite).
- Buffers execute-stage results in a small FIFO and retires one per cycle, unless held, as a clean one-cycle regwrite pulse.
- Supplies decode-stage forwarding of pending results over the register-file read port.
- Counts retired instructions.

Parameters:
- DATA_W, 8, data width; must match the register file.
- ADDR_W, 3, register address width; 8 registers, all writable.
- DEPTH, 2, writeback buffer entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents a result
- ex_ready  out  1  buffer can accept; equals count<DEPTH, combinational from registered count only
- ex_dest  in  ADDR_W  destination register
- ex_data  in  DATA_W  result value
- ex_regwrite  in  1  result writes the register file
- wb_hold  in  1  downstream stall; suppresses retirement
- write_reg  out  ADDR_W  to register file write_reg
- write_data  out  DATA_W  to register file write_data
- regwrite  out  1  to register file regwrite; registered one-cycle pulse
- fwd_reg  in  ADDR_W  decode read address (same value as the register file read_reg1)
- rf_data  in  DATA_W  register file read_data1
- fwd_data  out  DATA_W  forwarded operand
- fwd_hit  out  1  fwd_data came from a pending result, not from rf_data
- retire_count  out  8  retired-instruction counter

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; count=0; head and tail pointers 0.
  - regwrite=0, write_reg=0, write_data=0, retire_count=0.
  - ex_ready=1, so the handshake is usable on the first edge after release.
- Occupancy states, derived from count:
  - EMPTY (0): ex_ready=1.
  - PARTIAL (1..DEPTH-1): ex_ready=1.
  - FULL (DEPTH): ex_ready=0.
- Push: at an edge where ex_valid&ex_ready, write {ex_regwrite, ex_dest, ex_data} at tail; tail increments and wraps modulo DEPTH.
- Pop: at an edge where count>0 and wb_hold=0:
  - head entry loads the output register: regwrite<=entry.regwrite, write_reg<=entry.dest, write_data<=entry.data;
  - head increments and wraps; retire_count increments, 255 wraps to 0;
  - entries with regwrite=0 still pop and still count.
- No pop (empty or held): regwrite<=0; write_reg and write_data keep their last values. This keeps the write port stable for the level-sensitive register-file write.
- Push and pop at the same edge: count unchanged. This is legal in PARTIAL only, because ex_ready=0 when FULL.
- Latency: a result accepted at edge N into an empty FIFO, with wb_hold=0, appears with regwrite=1 for exactly the cycle after edge N+1. Sustained throughput is 1 per cycle.
- wb_hold=1: FIFO keeps filling until FULL; regwrite=0 for the whole hold; the first pop occurs at the first edge with wb_hold=0.
- Forwarding (combinational):
  - Candidates are FIFO entries that are valid with regwrite=1 and dest==fwd_reg, plus the output register when regwrite=1 and write_reg==fwd_reg.
  - Priority: youngest FIFO entry, then older FIFO entries, then the output register, then rf_data.
  - fwd_hit=1 when any candidate is selected; otherwise fwd_data=rf_data and fwd_hit=0.
- Reset mid-operation discards all buffered entries; no regwrite pulse may occur during or after the reset assertion.

Decomposition:
- Package pipe_pkg:
  - DATA_W and ADDR_W constants;
  - wb_entry_t struct {regwrite, dest[ADDR_W], data[DATA_W]}, shared with the execute stage.
- One sub-module, wb_fifo: DEPTH-entry circular buffer with count, full/empty, and parallel read-out of all entries with their valid bits for the forwarding comparators.
- Output register, retire counter and forwarding mux stay in writeback_stage.

Test Plan:
- Reset then single push {1,3,8'h5A} with wb_hold=0 -> cycle after next edge: regwrite=1, write_reg=3, write_data=5A for one cycle only; retire_count=1.
- Hold=1, push {1,2,8'h11} then {1,2,8'h22} -> ex_ready=0 after second push; fwd_reg=2 gives fwd_data=22, fwd_hit=1; release hold -> writes 11 then 22 on consecutive cycles.
- Push {0,4,8'hFF}, fwd_reg=4, rf_data=8'h07 -> fwd_data=07, fwd_hit=0; entry still retires, retire_count increments, regwrite stays 0.
- Back-to-back pushes every cycle with hold=0 for 10 results -> ex_ready constantly 1, count never exceeds 1, 10 regwrite pulses in order, retire_count=10.
- 256 retirements -> retire_count wraps to 0.
- Reset asserted while FULL -> regwrite drops to 0 immediately; after release, no write occurs and count=0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg: shared pipeline widths and the writeback entry type.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pipe_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic              regwrite;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_fifo: circular writeback buffer with age-ordered parallel read-out.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module wb_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  wb_entry_t             wr_entry,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]      valid
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible unless count marks it valid.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= wr_entry;
    end

    // Index 0 is the oldest entry (the head), higher indices are younger.
    always_comb begin
        entries = '0;
        valid   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries[k] = mem[head + PTR_W'(k)];
            valid[k]   = (CNT_W'(k) < count);
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | writeback_stage: buffers execute results, retires one per cycle to the     |
// | register file write port, forwards pending results. Rev 1.0                |
// +----------------------------------------------------------------------------+
module writeback_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ex_regwrite,
    input  logic              wb_hold,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              regwrite,
    input  logic [ADDR_W-1:0] fwd_reg,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_hit,
    output logic [7:0]        retire_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t             wr_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    occ_t                  occ;

    always_comb begin
        if (empty)     occ = OCC_EMPTY;
        else if (full) occ = OCC_FULL;
        else           occ = OCC_PARTIAL;
    end

    assign ex_ready = (occ != OCC_FULL);
    assign push     = ex_valid && ex_ready;
    assign pop      = (occ != OCC_EMPTY) && !wb_hold;

    assign wr_entry.regwrite = ex_regwrite;
    assign wr_entry.dest     = ex_dest;
    assign wr_entry.data     = ex_data;

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .entries  (entries),
        .valid    (valid)
    );

    // write_reg/write_data hold their value between pops so the level-sensitive
    // register-file write sees a stable address and data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite     <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            retire_count <= '0;
        end else if (pop) begin
            regwrite     <= entries[0].regwrite;
            write_reg    <= entries[0].dest;
            write_data   <= entries[0].data;
            retire_count <= retire_count + 8'd1;
        end else begin
            regwrite     <= 1'b0;
        end
    end

    // Lowest priority is evaluated first so younger matches overwrite older ones.
    always_comb begin
        fwd_data = rf_data;
        fwd_hit  = 1'b0;
        if (regwrite && (write_reg == fwd_reg)) begin
            fwd_data = write_data;
            fwd_hit  = 1'b1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k] && entries[k].regwrite && (entries[k].dest == fwd_reg)) begin
                fwd_data = entries[k].data;
                fwd_hit  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_writeback_stage: directed self-checking bench for writeback_stage.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_writeback_stage;

    logic       clk;
    logic       reset;
    logic       ex_valid;
    logic       ex_ready;
    logic [2:0] ex_dest;
    logic [7:0] ex_data;
    logic       ex_regwrite;
    logic       wb_hold;
    logic [2:0] write_reg;
    logic [7:0] write_data;
    logic       regwrite;
    logic [2:0] fwd_reg;
    logic [7:0] rf_data;
    logic [7:0] fwd_data;
    logic       fwd_hit;
    logic [7:0] retire_count;

    int checks;
    int errors;

    writeback_stage #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_dest      (ex_dest),
        .ex_data      (ex_data),
        .ex_regwrite  (ex_regwrite),
        .wb_hold      (wb_hold),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .regwrite     (regwrite),
        .fwd_reg      (fwd_reg),
        .rf_data      (rf_data),
        .fwd_data     (fwd_data),
        .fwd_hit      (fwd_hit),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [2:0] d, input logic [7:0] x);
        ex_valid    = v;
        ex_regwrite = rw;
        ex_dest     = d;
        ex_data     = x;
    endtask

    task automatic test_reset();
        reset = 1'b0; wb_hold = 1'b0; fwd_reg = 3'd0; rf_data = 8'h3C;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step(); step();
        checks++;
        if ({regwrite, write_reg, write_data, retire_count} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got rw=%b reg=%0d data=%h cnt=%0d want 0/0/00/0",
                     regwrite, write_reg, write_data, retire_count);
        end
        checks++;
        if (ex_ready !== 1'b1 || fwd_hit !== 1'b0 || fwd_data !== 8'h3C) begin
            errors++;
            $display("FAIL reset_ready_fwd got rdy=%b hit=%b fwd=%h want 1/0/3c", ex_ready, fwd_hit, fwd_data);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        drive(1'b1, 1'b1, 3'd3, 8'h5A);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        fwd_reg = 3'd3;
        #1;
        checks++;
        if (regwrite !== 1'b0 || fwd_hit !== 1'b1 || fwd_data !== 8'h5A) begin
            errors++;
            $display("FAIL single_buffered got rw=%b hit=%b fwd=%h want 0/1/5a", regwrite, fwd_hit, fwd_data);
        end
        step();
        checks++;
        if (regwrite !== 1'b1 || write_reg !== 3'd3 || write_data !== 8'h5A || retire_count !== 8'd1) begin
            errors++;
            $display("FAIL single_retire got rw=%b reg=%0d data=%h cnt=%0d want 1/3/5a/1",
                     regwrite, write_reg, write_data, retire_count);
        end
        step();
        checks++;
        if (regwrite !== 1'b0 || write_reg !== 3'd3 || write_data !== 8'h5A || retire_count !== 8'd1) begin
            errors++;
            $display("FAIL single_pulse_end got rw=%b reg=%0d data=%h cnt=%0d want 0/3/5a/1",
                     regwrite, write_reg, write_data, retire_count);
        end
    endtask

    task automatic test_hold();
        wb_hold = 1'b1;
        drive(1'b1, 1'b1, 3'd2, 8'h11);
        step();
        drive(1'b1, 1'b1, 3'd2, 8'h22);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        fwd_reg = 3'd2; rf_data = 8'h99;
        #1;
        checks++;
        if (ex_ready !== 1'b0 || fwd_hit !== 1'b1 || fwd_data !== 8'h22 || regwrite !== 1'b0) begin
            errors++;
            $display("FAIL hold_full got rdy=%b hit=%b fwd=%h rw=%b want 0/1/22/0", ex_ready, fwd_hit, fwd_data, regwrite);
        end
        step();
        checks++;
        if (regwrite !== 1'b0 || retire_count !== 8'd1) begin
            errors++;
            $display("FAIL hold_stall got rw=%b cnt=%0d want 0/1", regwrite, retire_count);
        end
        wb_hold = 1'b0;
        step();
        checks++;
        if (regwrite !== 1'b1 || write_data !== 8'h11 || retire_count !== 8'd2 || fwd_data !== 8'h22) begin
            errors++;
            $display("FAIL hold_first got rw=%b data=%h cnt=%0d fwd=%h want 1/11/2/22",
                     regwrite, write_data, retire_count, fwd_data);
        end
        step();
        checks++;
        if (regwrite !== 1'b1 || write_data !== 8'h22 || retire_count !== 8'd3 || fwd_hit !== 1'b1 || fwd_data !== 8'h22) begin
            errors++;
            $display("FAIL hold_second got rw=%b data=%h cnt=%0d hit=%b fwd=%h want 1/22/3/1/22",
                     regwrite, write_data, retire_count, fwd_hit, fwd_data);
        end
        step();
        checks++;
        if (regwrite !== 1'b0 || fwd_hit !== 1'b0 || fwd_data !== 8'h99) begin
            errors++;
            $display("FAIL hold_drained got rw=%b hit=%b fwd=%h want 0/0/99", regwrite, fwd_hit, fwd_data);
        end
    endtask

    task automatic test_no_regwrite();
        fwd_reg = 3'd4; rf_data = 8'h07;
        drive(1'b1, 1'b0, 3'd4, 8'hFF);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 8'h07) begin
            errors++;
            $display("FAIL norw_fwd got hit=%b fwd=%h want 0/07", fwd_hit, fwd_data);
        end
        step();
        checks++;
        if (regwrite !== 1'b0 || retire_count !== 8'd4 || write_reg !== 3'd4 || write_data !== 8'hFF) begin
            errors++;
            $display("FAIL norw_retire got rw=%b cnt=%0d reg=%0d data=%h want 0/4/4/ff",
                     regwrite, retire_count, write_reg, write_data);
        end
    endtask

    task automatic test_back_to_back();
        int bad_ready;
        int bad_write;
        bad_ready = 0;
        bad_write = 0;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) drive(1'b1, 1'b1, 3'(i), 8'h30 + 8'(i));
            else        drive(1'b0, 1'b0, 3'd0, 8'h00);
            #1;
            if (i < 10 && ex_ready !== 1'b1) bad_ready++;
            step();
            if (i >= 1 && (regwrite !== 1'b1 || write_reg !== 3'(i - 1) || write_data !== 8'h30 + 8'(i - 1)))
                bad_write++;
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL b2b_ready got %0d cycles with ex_ready low want 0", bad_ready);
        end
        checks++;
        if (bad_write != 0) begin
            errors++;
            $display("FAIL b2b_writes got %0d wrong retire cycles want 0", bad_write);
        end
        step();
        checks++;
        if (regwrite !== 1'b0 || retire_count !== 8'd14) begin
            errors++;
            $display("FAIL b2b_count got rw=%b cnt=%0d want 0/14", regwrite, retire_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 241; i++) begin
            drive(1'b1, 1'b0, 3'd1, 8'(i));
            step();
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        checks++;
        if (retire_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255 got cnt=%0d want 255", retire_count);
        end
        drive(1'b1, 1'b1, 3'd6, 8'hA5);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        checks++;
        if (retire_count !== 8'd0 || regwrite !== 1'b1 || write_data !== 8'hA5) begin
            errors++;
            $display("FAIL wrap_zero got cnt=%0d rw=%b data=%h want 0/1/a5", retire_count, regwrite, write_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pulses;
        // Reset while FULL under hold.
        wb_hold = 1'b1;
        drive(1'b1, 1'b1, 3'd5, 8'h55);
        step();
        drive(1'b1, 1'b1, 3'd5, 8'h66);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        checks++;
        if (ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_full_pre got rdy=%b want 0", ex_ready);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ex_ready !== 1'b1 || regwrite !== 1'b0 || retire_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_full_async got rdy=%b rw=%b cnt=%0d want 1/0/0", ex_ready, regwrite, retire_count);
        end
        step();
        reset = 1'b1;
        wb_hold = 1'b0;
        fwd_reg = 3'd5; rf_data = 8'h01;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (regwrite !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0 || retire_count !== 8'd0 || fwd_hit !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_full_after got pulses=%0d cnt=%0d hit=%b rdy=%b want 0/0/0/1",
                     pulses, retire_count, fwd_hit, ex_ready);
        end
        // Reset while a regwrite pulse is on the port.
        wb_hold = 1'b1;
        drive(1'b1, 1'b1, 3'd2, 8'h77);
        step();
        drive(1'b1, 1'b1, 3'd3, 8'h88);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        wb_hold = 1'b0;
        step();
        checks++;
        if (regwrite !== 1'b1 || write_data !== 8'h77) begin
            errors++;
            $display("FAIL rst_pulse_pre got rw=%b data=%h want 1/77", regwrite, write_data);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (regwrite !== 1'b0 || write_data !== 8'h00 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_pulse_drop got rw=%b data=%h rdy=%b want 0/00/1", regwrite, write_data, ex_ready);
        end
        step();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (regwrite !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0 || retire_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_pulse_after got pulses=%0d cnt=%0d want 0/0", pulses, retire_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_hold();
        test_no_regwrite();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
